mux5_rr_sched: RTL and testbench

Round-robin scheduler that shares the 5:1 select tree (inputs u, v, w, x, y; 3-bit select) among five requesters. It drives the select bus and a one-hot grant so that exactly one requester owns the mux output at a time. It enforces a maximum hold time per grant and inserts one idle cycle between owners so that downstream logic never sees a mid-cycle select change while `valid` is high.

---
 rtl/mux5_rr_sched_if.sv | 19 +
 rtl/mux5_rr_sched.sv | 106 ++++++++++
 tb/tb_mux5_rr_sched.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mux5_rr_sched_if.sv
// rtl/mux5_rr_sched_if.sv - request/grant/select bundle between the scheduler and its five requesters
interface mux5_rr_sched_if;
  logic [4:0] req;
  logic [4:0] gnt;
  logic [2:0] s;
  logic       valid;
  logic [2:0] owner;
  logic       preempt;

  modport master (
    input  req,
    output gnt, s, valid, owner, preempt
  );

  modport slave (
    output req,
    input  gnt, s, valid, owner, preempt
  );
endinterface

// File: rtl/mux5_rr_sched.sv
// rtl/mux5_rr_sched.sv - round-robin owner of a 5:1 select tree with hold limit and one idle cycle per handoff
module mux5_rr_sched #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  mux5_rr_sched_if.master  io_arb
);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_owner, w_owner_nxt;
  logic [2:0]       r_s, w_s_nxt;
  logic [4:0]       r_gnt, w_gnt_nxt;
  logic             r_preempt, w_preempt_nxt;

  logic             w_any_req;
  logic             w_own_req;
  logic             w_expire;
  logic [2:0]       w_winner;
  logic [2:0]       w_idx;

  assign w_any_req = |io_arb.req;
  assign w_own_req = io_arb.req[r_owner];
  assign w_expire  = (MAX_HOLD != 0) && (r_cnt == HOLD_LAST) && w_own_req;

  // Walk from farthest to nearest so the nearest set bit after the owner wins.
  always_comb begin
    w_winner = r_owner;
    w_idx    = 3'd0;
    for (int k = 5; k >= 1; k--) begin
      w_idx = 3'((int'(r_owner) + k) % 5);
      if (io_arb.req[w_idx]) begin
        w_winner = w_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_owner   <= 3'd4;
      r_s       <= 3'd0;
      r_gnt     <= 5'd0;
      r_preempt <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_owner   <= w_owner_nxt;
      r_s       <= w_s_nxt;
      r_gnt     <= w_gnt_nxt;
      r_preempt <= w_preempt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_any_req) w_state_nxt = ST_GRANT;
      ST_GRANT: if (!w_own_req || w_expire) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // A release on the expiry edge leaves preempt low because w_expire requires req[owner].
  always_comb begin
    w_gnt_nxt     = 5'd0;
    w_owner_nxt   = r_owner;
    w_s_nxt       = r_s;
    w_cnt_nxt     = r_cnt;
    w_preempt_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_owner_nxt = w_winner;
          w_s_nxt     = w_winner;
          w_gnt_nxt   = 5'd1 << w_winner;
          w_cnt_nxt   = '0;
        end
      end
      ST_GRANT: begin
        if (w_own_req && !w_expire) begin
          w_gnt_nxt = r_gnt;
          w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
        end else begin
          w_preempt_nxt = w_expire;
        end
      end
      default: ;
    endcase
  end

  assign io_arb.gnt     = r_gnt;
  assign io_arb.s       = r_s;
  assign io_arb.valid   = (r_state == ST_GRANT);
  assign io_arb.owner   = r_owner;
  assign io_arb.preempt = r_preempt;

endmodule

// File: tb/tb_mux5_rr_sched.sv
// tb/tb_mux5_rr_sched.sv - scoreboard bench for mux5_rr_sched at MAX_HOLD = 2, 8 and 0
module tb_mux5_rr_sched;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mux5_rr_sched_if if2();
  mux5_rr_sched_if if8();
  mux5_rr_sched_if if0();

  mux5_rr_sched #(.MAX_HOLD(2), .CNT_W(4)) u_dut2 (.clk(clk), .rst(rst), .io_arb(if2.master));
  mux5_rr_sched #(.MAX_HOLD(8), .CNT_W(4)) u_dut8 (.clk(clk), .rst(rst), .io_arb(if8.master));
  mux5_rr_sched #(.MAX_HOLD(0), .CNT_W(4)) u_dut0 (.clk(clk), .rst(rst), .io_arb(if0.master));

  int n_checks = 0;
  int n_errors = 0;

  // select-tree data inputs {u, v, w, x, y}
  localparam logic [4:0] MUX_UVWXY = 5'b10110;

  int         m_state [3];
  logic [2:0] m_owner [3];
  logic [2:0] m_s     [3];
  int         m_held  [3];
  logic       m_pre   [3];
  int         m_limit [3] = '{2, 8, 0};
  string      m_name  [3] = '{"dut2", "dut8", "dut0"};

  logic [12:0] exp_q[$];
  int          rr_owner_q[$];
  int          rr_m_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic mux_tree(input logic [2:0] sel);
    logic [4:0] v;
    v = MUX_UVWXY;
    case (sel)
      3'd0:    return v[4];
      3'd1:    return v[3];
      3'd2:    return v[2];
      3'd3:    return v[1];
      3'd4:    return v[0];
      default: return 1'bx;
    endcase
  endfunction

  function automatic logic [12:0] obs_vec(input int d);
    case (d)
      0:       return {if2.gnt, if2.s, if2.valid, if2.owner, if2.preempt};
      1:       return {if8.gnt, if8.s, if8.valid, if8.owner, if8.preempt};
      default: return {if0.gnt, if0.s, if0.valid, if0.owner, if0.preempt};
    endcase
  endfunction

  function automatic logic [12:0] exp_vec(input int d);
    logic [4:0] g;
    g = (m_state[d] != 0) ? (5'd1 << m_owner[d]) : 5'd0;
    return {g, m_s[d], (m_state[d] != 0), m_owner[d], m_pre[d]};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_state[d] = 0;
      m_owner[d] = 3'd4;
      m_s[d]     = 3'd0;
      m_held[d]  = 0;
      m_pre[d]   = 1'b0;
    end
  endtask

  task automatic model_step(input int d, input logic [4:0] r);
    logic [2:0] c;
    logic       found;
    if (m_state[d] == 0) begin
      m_pre[d] = 1'b0;
      c = m_owner[d];
      found = 1'b0;
      for (int k = 0; k < 5; k++) begin
        c = (c == 3'd4) ? 3'd0 : c + 3'd1;
        if (!found && r[c]) begin
          found      = 1'b1;
          m_owner[d] = c;
          m_s[d]     = c;
          m_held[d]  = 1;
          m_state[d] = 1;
        end
      end
    end else if (!r[m_owner[d]]) begin
      m_state[d] = 0;
      m_pre[d]   = 1'b0;
    end else if (m_limit[d] != 0 && m_held[d] == m_limit[d]) begin
      m_state[d] = 0;
      m_pre[d]   = 1'b1;
    end else begin
      m_held[d]++;
    end
  endtask

  task automatic step(input logic [4:0] r2, input logic [4:0] r8, input logic [4:0] r0);
    if2.req = r2;
    if8.req = r8;
    if0.req = r0;
    model_step(0, r2);
    model_step(1, r8);
    model_step(2, r0);
    for (int d = 0; d < 3; d++) exp_q.push_back(exp_vec(d));
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      logic [12:0] e;
      e = exp_q.pop_front();
      check_eq({m_name[d], "_cycle"}, 32'(obs_vec(d)), 32'(e));
    end
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      check_eq({m_name[d], "_reset"}, 32'(obs_vec(d)), 32'({5'b0, 3'b000, 1'b0, 3'd4, 1'b0}));
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [4:0] tab2 [8] = '{5'h00, 5'h00, 5'h01, 5'h01, 5'h00, 5'h00, 5'h00, 5'h00};
  logic [4:0] tab8 [8] = '{5'h00, 5'h00, 5'h08, 5'h08, 5'h08, 5'h00, 5'h09, 5'h09};
  logic [4:0] tab0 [8] = '{5'h00, 5'h00, 5'h08, 5'h08, 5'h08, 5'h00, 5'h09, 5'h09};

  initial begin
    int   m_exp [5] = '{1, 0, 1, 1, 0};
    logic prev2;
    int   valid0_cnt;
    int   pre0_cnt;

    if2.req = 5'd0;
    if8.req = 5'd0;
    if0.req = 5'd0;
    model_reset();
    async_reset();

    for (int i = 0; i < 4; i++) step(5'h01, 5'h01, 5'h01);
    async_reset();
    step(5'h01, 5'h01, 5'h01);
    check_eq("post_reset_gnt", 32'(if2.gnt), 32'h01);
    check_eq("post_reset_s", 32'(if2.s), 32'h0);
    step(5'h00, 5'h00, 5'h00);
    async_reset();

    for (int i = 0; i < 20; i++) begin
      rr_owner_q.push_back(i % 5);
      rr_m_q.push_back(m_exp[i % 5]);
    end
    prev2 = 1'b0;
    valid0_cnt = 0;
    pre0_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step(5'h1f, 5'h10, 5'h04);
      if (if2.valid && !prev2 && rr_owner_q.size() > 0) begin
        check_eq("rr_owner", 32'(if2.owner), 32'(rr_owner_q.pop_front()));
        check_eq("mux_m", 32'(mux_tree(if2.s)), 32'(rr_m_q.pop_front()));
      end
      prev2 = if2.valid;
      if (if0.valid) valid0_cnt++;
      if (if0.preempt) pre0_cnt++;
    end
    check_eq("rr_grant_count", 32'(rr_owner_q.size()), 32'd6);
    check_eq("unlimited_valid", 32'(valid0_cnt), 32'd40);
    check_eq("unlimited_preempt", 32'(pre0_cnt), 32'd0);

    for (int i = 0; i < 8; i++) begin
      step(tab2[i], tab8[i], tab0[i]);
      if (i == 4) check_eq("release_on_expiry_preempt", 32'(if2.preempt), 32'd0);
    end
    check_eq("wrap_owner", 32'(if8.owner), 32'd0);
    check_eq("wrap_valid", 32'(if8.valid), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
